input_route_unit: RTL
=====================

INPUT_ROUTE_UNIT -- requirements
Module: input_route_unit

Interface
REQ-001 SHALL have parameters: DATA_WIDTH, default 8, flit width; FIFO_DEPTH, default 4, input buffer depth (power of two, at least 2); REQUEST_WIDTH, default 2, output-port index width; LOCAL_X, default 0, router X coordinate; LOCAL_Y, default 0, router Y coordinate.
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 rst  in  1  reset, asynchronous and active-low.
REQ-004 flitIn  in  DATA_WIDTH  flit from upstream link.
REQ-005 flitInValid  in  1  flitIn valid.
REQ-006 flitInReady  out  1  FIFO not full.
REQ-007 routeReserveRequestValid  out  1  path request to switch control.
REQ-008 routeReserveRequest  out  REQUEST_WIDTH  requested output port.
REQ-009 routeReserveStatus  in  1  one-cycle grant pulse from switch control.
REQ-010 routeRelieve  out  1  one-cycle path release pulse.
REQ-011 flitOut  out  DATA_WIDTH  flit to crossbar.
REQ-012 flitOutValid  out  1  flitOut valid.
REQ-013 flitOutReady  in  1  crossbar/downstream accepts flit.
REQ-014 protocolError  out  1  sticky flag: non-head flit seen while idle.

Function
REQ-015 Flit type SHALL be flit[DATA_WIDTH-1:DATA_WIDTH-2]: 00 body, 01 head, 10 tail, 11 head+tail (single-flit packet).
REQ-016 Head destination SHALL be flit[0]=destX, flit[1]=destY.
REQ-017 XY routing SHALL select port 1 (X neighbour) if destX differs from LOCAL_X, else port 2 (Y neighbour) if destY differs from LOCAL_Y, else port 0 (local); port 3 is never requested.
REQ-018 Upstream write SHALL occur when flitInValid and flitInReady; flitInReady is low when the FIFO is full; there is no same-cycle write-through when full.
REQ-019 FIFO read data SHALL be registered-free at the FIFO front; a pop occurs on flitOutValid and flitOutReady, or on a drop (REQ-021).
REQ-020 FSM states SHALL be IDLE, REQUEST, FORWARD.
REQ-021 IDLE: on a head or head+tail flit at the front, go to REQUEST next cycle and register the computed port into routeReserveRequest; on a body or tail flit, pop it and set protocolError.
REQ-022 REQUEST: hold routeReserveRequestValid=1 with routeReserveRequest stable; on routeReserveStatus=1, go to FORWARD next cycle; no flit is output in REQUEST.
REQ-023 FORWARD: flitOutValid = FIFO not empty; keep routeReserveRequestValid=1 and routeReserveRequest stable; an empty FIFO stalls without state change.
REQ-024 The cycle the tail or head+tail flit transfers (flitOutValid and flitOutReady) SHALL assert routeRelieve for exactly that cycle, and the FSM returns to IDLE.
REQ-025 routeReserveRequestValid SHALL deassert from the cycle after the relieve cycle; the next request rises no earlier than one cycle after IDLE is re-entered.
REQ-026 Head-to-request latency: a head written at edge t SHALL give routeReserveRequestValid=1 after edge t+2, when the FSM was IDLE at edge t.
REQ-027 A head flit arriving while in FORWARD SHALL remain buffered until the current packet's tail is released.

Reset
REQ-028 Reset SHALL set FSM=IDLE, FIFO empty, flitInReady=1, flitOutValid=0, routeReserveRequestValid=0, routeReserveRequest=0, routeRelieve=0, protocolError=0.
REQ-029 Reset asserted mid-packet SHALL discard buffered flits and SHALL NOT emit routeRelieve; switch control is reset on the same rst.

Configuration
REQ-030 Macro IRU_PKT_COUNT_EN, when defined, SHALL add output pktCount, 16 bits, reset 0, incremented on each routeRelieve pulse and wrapping 0xFFFF->0.
REQ-031 When IRU_PKT_COUNT_EN is not defined, the pktCount port and its logic SHALL be absent and behaviour is otherwise identical.

Structure
REQ-032 Shared package SHALL hold the flit type encodings, the port indices LOCAL=0/XPORT=1/YPORT=2, and the FSM state encodings.
REQ-033 The FIFO SHALL be a separate sub-module flit_fifo, parameterized by DATA_WIDTH and FIFO_DEPTH, with full/empty flags and a wrap-around pointer plus count.

Verification
REQ-034 LOCAL=(0,0), head 0x42 (dest X=0, Y=1), status pulse 2 cycles later -> request=2, valid held, flitOut 0x42 on the cycle after status.
REQ-035 3-flit packet 0x43,0x05,0x80 with flitOutReady toggling 1,0,1,0 -> flits out in order, routeRelieve one cycle with 0x80, valid low the next cycle.
REQ-036 Single flit 0xC0 at LOCAL=(0,0) -> request=0; routeRelieve is asserted in the same cycle as its transfer.
REQ-037 5 flits pushed with flitOutReady=0, FIFO_DEPTH=4 -> flitInReady=0 after the 4th write, 5th held; after one pop, 5th accepted.
REQ-038 Body flit 0x11 while IDLE -> popped, protocolError=1 sticky, no request; rst low mid-FORWARD -> all outputs at reset values, no routeRelieve.

Source files
------------

// File: rtl/input_route_unit_pkg.sv
// Shared definitions for the router input unit: flit type codes, output
// port indices, FSM states and the XY route helper.
package input_route_unit_pkg;

  typedef enum logic [1:0] {
    FLIT_BODY   = 2'b00,
    FLIT_HEAD   = 2'b01,
    FLIT_TAIL   = 2'b10,
    FLIT_SINGLE = 2'b11
  } flitType_e;

  localparam logic [1:0] LOCAL = 2'd0;
  localparam logic [1:0] XPORT = 2'd1;
  localparam logic [1:0] YPORT = 2'd2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQUEST = 2'd1,
    FORWARD = 2'd2
  } iruState_e;

  // X is resolved first, then Y; port 3 is never produced.
  function automatic logic [1:0] xyRoute(input logic destX, input logic destY,
                                         input int localX, input int localY);
    logic [1:0] port;
    port = LOCAL;
    if (int'(destX) != localX) begin
      port = XPORT;
    end else if (int'(destY) != localY) begin
      port = YPORT;
    end
    return port;
  endfunction

endpackage

// File: rtl/input_route_unit_if.sv
// Link/switch-control bundle of the input route unit; slave is the unit
// side, master is the surrounding router/testbench side.
interface input_route_unit_if
  import input_route_unit_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int REQUEST_WIDTH = 2
) ();

  logic [DATA_WIDTH-1:0]    flitIn;
  logic                     flitInValid;
  logic                     flitInReady;
  logic                     routeReserveRequestValid;
  logic [REQUEST_WIDTH-1:0] routeReserveRequest;
  logic                     routeReserveStatus;
  logic                     routeRelieve;
  logic [DATA_WIDTH-1:0]    flitOut;
  logic                     flitOutValid;
  logic                     flitOutReady;
  logic                     protocolError;

  modport slave (
    input  flitIn, flitInValid, routeReserveStatus, flitOutReady,
    output flitInReady, routeReserveRequestValid, routeReserveRequest,
           routeRelieve, flitOut, flitOutValid, protocolError
  );

  modport master (
    output flitIn, flitInValid, routeReserveStatus, flitOutReady,
    input  flitInReady, routeReserveRequestValid, routeReserveRequest,
           routeRelieve, flitOut, flitOutValid, protocolError
  );

endinterface

// File: rtl/input_route_unit_flit_fifo.sv
// Input flit buffer: wrap-around pointers plus occupancy count, front entry
// visible combinationally so the FSM can inspect the head flit.
module flit_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] wrData,
  input  logic                  wrEn,
  input  logic                  rdEn,
  output logic [DATA_WIDTH-1:0] rdData,
  output logic                  full,
  output logic                  empty
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wrPtrReg;
  logic [PTR_W-1:0]      rdPtrReg;
  logic [CNT_W-1:0]      countReg;
  logic                  wrAccept;
  logic                  rdAccept;

  assign full     = (countReg == CNT_W'(FIFO_DEPTH));
  assign empty    = (countReg == '0);
  assign wrAccept = wrEn && !full;
  assign rdAccept = rdEn && !empty;
  assign rdData   = mem[rdPtrReg];

  genvar gi;
  generate
    for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (wrAccept && (wrPtrReg == PTR_W'(gi))) begin
          mem[gi] <= wrData;
        end
      end
    end
  endgenerate

  // Depth is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrPtrReg <= '0;
      rdPtrReg <= '0;
      countReg <= '0;
    end else begin
      if (wrAccept) begin
        wrPtrReg <= wrPtrReg + PTR_W'(1);
      end
      if (rdAccept) begin
        rdPtrReg <= rdPtrReg + PTR_W'(1);
      end
      case ({wrAccept, rdAccept})
        2'b10:   countReg <= countReg + CNT_W'(1);
        2'b01:   countReg <= countReg - CNT_W'(1);
        default: countReg <= countReg;
      endcase
    end
  end

endmodule

// File: rtl/input_route_unit.sv
// Router input unit: buffers flits, XY-routes each head, holds the path
// reservation until the tail leaves. Define IRU_PKT_COUNT_EN to add pktCount.
module input_route_unit
  import input_route_unit_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int FIFO_DEPTH    = 4,
  parameter int REQUEST_WIDTH = 2,
  parameter int LOCAL_X       = 0,
  parameter int LOCAL_Y       = 0
) (
  input  logic                clk,
  input  logic                rst,
  input_route_unit_if.slave   bus
`ifdef IRU_PKT_COUNT_EN
  ,
  output logic [15:0]         pktCount
`endif
);

  logic [DATA_WIDTH-1:0]    frontFlit;
  logic                     fifoFull;
  logic                     fifoEmpty;
  logic                     fifoPop;
  flitType_e                frontType;
  logic                     frontIsHead;
  logic                     frontIsTail;
  logic                     transfer;
  logic                     relieve;
  logic                     drop;
  logic [1:0]               routePort;
  iruState_e                stateReg;
  logic                     reqValidReg;
  logic [REQUEST_WIDTH-1:0] reqPortReg;
  logic                     protocolErrorReg;

  flit_fifo #(
    .DATA_WIDTH(DATA_WIDTH),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .wrData(bus.flitIn),
    .wrEn  (bus.flitInValid),
    .rdEn  (fifoPop),
    .rdData(frontFlit),
    .full  (fifoFull),
    .empty (fifoEmpty)
  );

  assign frontType   = flitType_e'(frontFlit[DATA_WIDTH-1 -: 2]);
  assign frontIsHead = (frontType == FLIT_HEAD) || (frontType == FLIT_SINGLE);
  assign frontIsTail = (frontType == FLIT_TAIL) || (frontType == FLIT_SINGLE);
  assign routePort   = xyRoute(frontFlit[0], frontFlit[1], LOCAL_X, LOCAL_Y);

  assign bus.flitOutValid = (stateReg == FORWARD) && !fifoEmpty;
  assign transfer         = bus.flitOutValid && bus.flitOutReady;
  assign relieve          = transfer && frontIsTail;
  // Anything other than a head reaching the front while idle is discarded.
  assign drop             = (stateReg == IDLE) && !fifoEmpty && !frontIsHead;
  assign fifoPop          = transfer || drop;

  assign bus.flitInReady              = !fifoFull;
  assign bus.flitOut                  = frontFlit;
  assign bus.routeRelieve             = relieve;
  assign bus.routeReserveRequestValid = reqValidReg;
  assign bus.routeReserveRequest      = reqPortReg;
  assign bus.protocolError            = protocolErrorReg;

  // The request is raised one cycle after REQUEST is entered; a grant only
  // counts once the request is actually visible to switch control.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stateReg         <= IDLE;
      reqValidReg      <= 1'b0;
      reqPortReg       <= '0;
      protocolErrorReg <= 1'b0;
    end else begin
      if (drop) begin
        protocolErrorReg <= 1'b1;
      end
      case (stateReg)
        IDLE: begin
          if (!fifoEmpty && frontIsHead) begin
            stateReg   <= REQUEST;
            reqPortReg <= REQUEST_WIDTH'(routePort);
          end
        end
        REQUEST: begin
          if (!reqValidReg) begin
            reqValidReg <= 1'b1;
          end else if (bus.routeReserveStatus) begin
            stateReg <= FORWARD;
          end
        end
        FORWARD: begin
          if (relieve) begin
            stateReg    <= IDLE;
            reqValidReg <= 1'b0;
          end
        end
        default: begin
          stateReg    <= IDLE;
          reqValidReg <= 1'b0;
        end
      endcase
    end
  end

`ifdef IRU_PKT_COUNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pktCount <= 16'd0;
    end else if (relieve) begin
      pktCount <= pktCount + 16'd1;
    end
  end
`endif

endmodule
